// File: rtl/spi_flash_reader.sv
// Purpose : iomem-mapped SPI mode-0 initiator that shifts out opcode/address and captures flash reply bytes.
// Latency : iomem ready one cycle after sel; SPI bit = 2*CLK_DIV cycles, cs-low = nbits*2*CLK_DIV + CLK_DIV.
// Backpr. : none on SPI; a CMD write while busy is acknowledged and dropped.
//
// Ports:
//   clk, resetn                 system clock, async active-low reset
//   sel/addr/wstrb/wdata        iomem request (addr[8]=1 selects the reply buffer window)
//   rdata/ready                 iomem response, ready is a one-cycle pulse
//   spi_clk/spi_cs/spi_mosi     SPI outputs (clk idles low, cs active low)
//   spi_miso                    SPI input from flash
//   busy/done_strobe            transaction in progress / one-cycle end pulse
module spi_flash_reader #(
  parameter int CLK_DIV   = 2,
  parameter int BUF_WORDS = 64
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [8:0]  addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        spi_clk,
  output logic        spi_cs,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        busy,
  output logic        done_strobe
);

  localparam int AW = $clog2(BUF_WORDS);
  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] DIV_RISE = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_END  = DW'(2 * CLK_DIV - 1);
  localparam logic [8:0]    MAX_LEN  = 9'(4 * BUF_WORDS);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [4:0]    bit_q, bit_d;
  logic [30:0]   shift_q, shift_d;
  logic [7:0]    rx_q, rx_d;
  logic [8:0]    cnt_q, cnt_d;
  logic [7:0]    op_q, op_d;
  logic [8:0]    len_q, len_d;
  logic          aen_q, aen_d;
  logic [23:0]   addr_q, addr_d;
  logic          done_q, done_d;
  logic          dstb_q, dstb_d;
  logic          sclk_q, sclk_d;
  logic          cs_n_q, cs_n_d;
  logic          mosi_q, mosi_d;
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;

  // The request is captured on the first sel cycle and acted on in the ready
  // cycle, so a start makes cs fall the cycle after the ack.
  logic          req_cmd_q, req_cmd_d;
  logic          req_adr_q, req_adr_d;
  logic          req_wr_q, req_wr_d;
  logic [3:0]    req_wstrb_q, req_wstrb_d;
  logic [24:0]   req_wdata_q, req_wdata_d;

  logic [31:0]   buf_q [BUF_WORDS];
  logic          buf_we;
  logic [31:0]   rd_val;
  logic [2:0]    nxt;

  logic [7:0]    op_new;
  logic [8:0]    len_new;
  logic [8:0]    len_clamp;
  logic          aen_new;
  logic          unused_wdata;

  assign unused_wdata = ^wdata[31:25];

  assign op_new    = req_wstrb_q[0] ? req_wdata_q[7:0] : op_q;
  assign len_new   = {req_wstrb_q[2] ? req_wdata_q[16] : len_q[8],
                      req_wstrb_q[1] ? req_wdata_q[15:8] : len_q[7:0]};
  assign aen_new   = req_wstrb_q[3] ? req_wdata_q[24] : aen_q;
  assign len_clamp = (len_new > MAX_LEN) ? MAX_LEN : len_new;

  assign busy        = (state_q != S_IDLE);
  assign spi_clk     = sclk_q;
  assign spi_cs      = cs_n_q;
  assign spi_mosi    = mosi_q;
  assign done_strobe = dstb_q;
  assign ready       = ready_q;
  assign rdata       = rdata_q;

  always_comb begin
    rd_val = '0;
    if (addr[8]) begin
      rd_val = buf_q[addr[2 +: AW]];
    end else begin
      case (addr[7:0])
        8'h00:   rd_val = {7'b0, aen_q, 7'b0, len_q, op_q};
        8'h04:   rd_val = {8'b0, addr_q};
        8'h08:   rd_val = {15'b0, cnt_q, 6'b0, done_q, busy};
        default: rd_val = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    len_d       = len_q;
    aen_d       = aen_q;
    addr_d      = addr_q;
    done_d      = done_q;
    dstb_d      = 1'b0;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    ready_d     = sel & ~ready_q;
    rdata_d     = '0;
    req_cmd_d   = req_cmd_q;
    req_adr_d   = req_adr_q;
    req_wr_d    = req_wr_q;
    req_wstrb_d = req_wstrb_q;
    req_wdata_d = req_wdata_q;
    buf_we      = 1'b0;
    nxt         = state_q;

    // iomem request capture and read response
    if (sel && !ready_q) begin
      req_cmd_d   = !addr[8] && (addr[7:0] == 8'h00);
      req_adr_d   = !addr[8] && (addr[7:0] == 8'h04);
      req_wr_d    = (wstrb != 4'b0);
      req_wstrb_d = wstrb;
      req_wdata_d = wdata[24:0];
      if (wstrb == 4'b0) rdata_d = rd_val;
    end

    // SPI sequencing: div counts through one bit period, spi_clk rises at
    // the midpoint and falls at the bit boundary where mosi also advances.
    case (state_q)
      S_CMD, S_ADDR, S_DATA: begin
        div_d = (div_q == DIV_END) ? '0 : div_q + 1'b1;
        if (div_q == DIV_RISE) begin
          sclk_d = 1'b1;
          if (state_q == S_DATA) rx_d = {rx_q[6:0], spi_miso};
        end
        if (div_q == DIV_END) begin
          sclk_d  = 1'b0;
          bit_d   = bit_q + 5'd1;
          shift_d = {shift_q[29:0], 1'b0};
          case (state_q)
            S_CMD: if (bit_q == 5'd7) begin
              bit_d = '0;
              nxt   = aen_q ? S_ADDR : ((len_q != 9'd0) ? S_DATA : S_HOLD);
            end
            S_ADDR: if (bit_q == 5'd23) begin
              bit_d = '0;
              nxt   = (len_q != 9'd0) ? S_DATA : S_HOLD;
            end
            default: if (bit_q == 5'd7) begin
              bit_d  = '0;
              buf_we = 1'b1;
              cnt_d  = cnt_q + 9'd1;
              if (cnt_q + 9'd1 == len_q) nxt = S_HOLD;
            end
          endcase
          state_d = nxt;
          mosi_d  = (nxt == S_CMD || nxt == S_ADDR) ? shift_q[30] : 1'b0;
        end
      end
      S_HOLD: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_RISE) begin
          div_d   = '0;
          state_d = S_IDLE;
          cs_n_d  = 1'b1;
          done_d  = 1'b1;
          dstb_d  = 1'b1;
        end
      end
      default: ;
    endcase

    // register writes land in the ack cycle
    if (ready_q && req_wr_q) begin
      if (req_adr_q) begin
        addr_d = {req_wstrb_q[2] ? req_wdata_q[23:16] : addr_q[23:16],
                  req_wstrb_q[1] ? req_wdata_q[15:8]  : addr_q[15:8],
                  req_wstrb_q[0] ? req_wdata_q[7:0]   : addr_q[7:0]};
      end
      if (req_cmd_q && state_q == S_IDLE) begin
        op_d    = op_new;
        len_d   = len_clamp;
        aen_d   = aen_new;
        state_d = S_CMD;
        div_d   = '0;
        bit_d   = '0;
        shift_d = {op_new[6:0], addr_q};
        mosi_d  = op_new[7];
        sclk_d  = 1'b0;
        cs_n_d  = 1'b0;
        done_d  = 1'b0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      rx_q        <= '0;
      cnt_q       <= '0;
      op_q        <= '0;
      len_q       <= '0;
      aen_q       <= 1'b0;
      addr_q      <= '0;
      done_q      <= 1'b0;
      dstb_q      <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      req_cmd_q   <= 1'b0;
      req_adr_q   <= 1'b0;
      req_wr_q    <= 1'b0;
      req_wstrb_q <= '0;
      req_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      len_q       <= len_d;
      aen_q       <= aen_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      dstb_q      <= dstb_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      req_cmd_q   <= req_cmd_d;
      req_adr_q   <= req_adr_d;
      req_wr_q    <= req_wr_d;
      req_wstrb_q <= req_wstrb_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  // Reply buffer: no reset, contents are undefined until written.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[cnt_q[2 +: AW]][{cnt_q[1:0], 3'b000} +: 8] <= rx_q;
  end

endmodule
